exu_alu_shared_dpath: RTL and testbench
=======================================

Name: exu_alu_shared_dpath

Overview:
Next-generation shared ALU datapath for the EXU, with NREQ requestor channels (channel 0 = ALU, channel 1 = BJP, extra channels reserved for future units).
Adds valid/ready handshakes, configurable arbitration, a registered result stage, and an iterative multi-cycle shifter.
Supports add/sub, signed and unsigned compare, logic ops, shifts and move-op2 (LUI) on an XLEN-wide datapath.
Sits between the EXU decode/dispatch units and the write-back / branch-resolve logic.

Parameters:
XLEN, 32, datapath width; power of 2, at least 8.
NREQ, 2, number of requestor channels; 1 to 8.
SHIFT_STEP, 1, bits shifted per cycle; power of 2, at most XLEN.
RR_ARB, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NREQ  per-channel request valid.
req_ready  out  NREQ  per-channel accept; one-hot or zero.
req_op  in  NREQ*4  per-channel opcode; channel i occupies bits [4i+3:4i].
req_op1  in  NREQ*XLEN  per-channel operand 1.
req_op2  in  NREQ*XLEN  per-channel operand 2.
rsp_valid  out  NREQ  one-hot result valid, asserted toward the owning channel.
rsp_ready  in  NREQ  per-channel result accept.
rsp_res  out  XLEN  result, shared by all channels.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state goes to IDLE; rsp_valid, rsp_res, busy and owner are cleared to 0; the round-robin pointer is set to 0.
  - req_ready is forced to 0 while rst_n is low.
  - A reset during SHIFT or RESP aborts the operation; no response is ever issued for it.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - req_ready is combinational and equals the arbiter grant, masked by req_valid.
  - On accept, latch owner index and opcode.
  - Non-shift op: compute the result, register it, go to RESP. rsp_valid rises the next cycle (latency 1).
  - Shift op: load op1 into the shift register and set count to op2[log2(XLEN)-1:0].
  - If the shift count is 0, go directly to RESP with result = op1. Otherwise go to SHIFT.
- SHIFT:
  - Each cycle, shift by SHIFT_STEP if count is at least SHIFT_STEP; otherwise shift by count.
  - Decrement count by the amount shifted.
  - When count reaches 0, go to RESP.
  - Latency = 1 + ceil(n/SHIFT_STEP) cycles from accept to rsp_valid.
  - SRA fills with the sign bit; SLL and SRL fill with zeros.
- RESP:
  - rsp_valid[owner] = 1 and rsp_res is held stable until rsp_ready[owner] is seen.
  - rsp_ready on other channels is ignored.
  - After the handshake, go to IDLE. No accept happens in the same cycle, so peak throughput is 1 operation per 2 cycles.
- Arbitration:
  - Fixed priority: lowest valid index wins.
  - Round-robin: search starts at the pointer. On accept, the pointer becomes grant+1 mod NREQ.
  - The pointer changes only on accept.
  - req_valid may drop without an accept; no grant is retained.
- Arithmetic (XLEN bits, wrap-around, no flags):
  - ADD: op1+op2.
  - SUB: op1-op2, implemented as op1 + ~op2 + 1.
  - SLT: signed compare. SLTU: unsigned compare. Both return 0 or 1, zero-extended.
  - MVOP2: result = op2.
  - Reserved opcodes: result 0, latency 1, response still issued.
- rsp_res keeps its last value outside RESP. busy = (state != IDLE).

Decomposition:
- Shared defines file (same file that holds XLEN):
  - ALU_OP_W = 4.
  - Opcode constants: ADD 0, SUB 1, SLT 2, SLTU 3, XOR 4, OR 5, AND 6, SLL 7, SRL 8, SRA 9, MVOP2 10; 11 to 15 reserved.
  - FSM state encodings.
- One sub-module, exu_alu_req_arb: parametrised by NREQ and RR_ARB. Inputs: valid vector and pointer. Outputs: one-hot grant and encoded index.

Test Plan:
- Channel 0 ADD 0x7FFFFFFF + 0x00000001, rsp_ready held high -> rsp_valid[0] one cycle after accept, rsp_res 0x80000000. SUB 0 - 1 -> 0xFFFFFFFF.
- SLT 0xFFFFFFFF vs 0x00000001 -> 1. SLTU with the same operands -> 0. MVOP2 op2 = 0x12345000 -> 0x12345000. Opcode 15 -> 0.
- SRA 0x80000000 by 31, SHIFT_STEP 1 -> rsp_valid 32 cycles after accept, rsp_res 0xFFFFFFFF. Same with SHIFT_STEP 8 -> 5 cycles. Shift by 0 -> 1 cycle, rsp_res = op1.
- Both channels valid every cycle, RR_ARB 1 -> grants alternate 0,1,0,1. With RR_ARB 0 -> channel 0 always wins; channel 1 stalls.
- rsp_ready[owner] held low for 5 cycles, other channel's rsp_ready high -> rsp_valid and rsp_res stable, no new accept, busy stays 1.
- rst_n pulled low mid-SHIFT (SLL by 20) -> immediate IDLE, rsp_valid 0, busy 0, no response. After release, next request completes normally.

Source files
------------

// File: rtl/exu_alu_shared_dpath_pkg.sv
// Shared definitions for the EXU shared ALU datapath: widths, opcodes and FSM states.
package exu_alu_shared_dpath_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB   = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_SLT   = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_SLTU  = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_XOR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_OR    = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_AND   = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_SLL   = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_SRL   = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_SRA   = 4'd9;
    localparam logic [ALU_OP_W-1:0] OP_MVOP2 = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/exu_alu_req_arb.sv
// Request arbiter: fixed priority (lowest index) or round-robin starting at ptr_i.
module exu_alu_req_arb #(
    parameter int NREQ   = 2,
    parameter int RR_ARB = 1,
    parameter int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        logic found;
        int   cand;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        // Walk the channels in priority order; the first valid one wins.
        for (int off = 0; off < NREQ; off++) begin
            cand = (RR_ARB != 0) ? int'(ptr_i) + off : off;
            if (cand >= NREQ) cand = cand - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && (cand == i) && valid_i[i]) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    idx_o      = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/exu_alu_shared_dpath.sv
// Shared EXU ALU: arbitrates NREQ channels, computes in one cycle or shifts iteratively,
// and returns a registered result to the owning channel over a valid/ready handshake.
module exu_alu_shared_dpath #(
    parameter int XLEN       = exu_alu_shared_dpath_pkg::XLEN,
    parameter int NREQ       = 2,
    parameter int SHIFT_STEP = 1,
    parameter int RR_ARB     = 1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NREQ-1:0]                                 req_valid,
    output logic [NREQ-1:0]                                 req_ready,
    input  logic [NREQ*exu_alu_shared_dpath_pkg::ALU_OP_W-1:0] req_op,
    input  logic [NREQ*XLEN-1:0]                            req_op1,
    input  logic [NREQ*XLEN-1:0]                            req_op2,
    output logic [NREQ-1:0]                                 rsp_valid,
    input  logic [NREQ-1:0]                                 rsp_ready,
    output logic [XLEN-1:0]                                 rsp_res,
    output logic                                            busy,
    output logic [1:0]                                      dbg_state
);
    import exu_alu_shared_dpath_pkg::*;

    localparam int SH_W  = $clog2(XLEN);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [SH_W:0] STEP = (SH_W + 1)'(SHIFT_STEP);

    alu_state_e          state_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [ALU_OP_W-1:0] op_q;
    logic [XLEN-1:0]     shreg_q;
    logic [SH_W-1:0]     cnt_q;
    logic [XLEN-1:0]     res_q;
    logic [NREQ-1:0]     rsp_valid_q;

    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                accept;
    logic [ALU_OP_W-1:0] sel_op;
    logic [XLEN-1:0]     sel_op1;
    logic [XLEN-1:0]     sel_op2;
    logic [SH_W-1:0]     sel_amt;
    logic [XLEN-1:0]     alu_res_d;
    logic [SH_W:0]       step_amt;
    logic [XLEN-1:0]     shreg_d;
    logic [SH_W-1:0]     cnt_d;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [NREQ-1:0]     owner_oh;

    function automatic logic [XLEN-1:0] alu_calc(input logic [ALU_OP_W-1:0] op,
                                                 input logic [XLEN-1:0]     a,
                                                 input logic [XLEN-1:0]     b);
        logic [XLEN-1:0] r;
        r = '0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a + ~b + XLEN'(1);
            OP_SLT:   r[0] = $signed(a) < $signed(b);
            OP_SLTU:  r[0] = a < b;
            OP_XOR:   r = a ^ b;
            OP_OR:    r = a | b;
            OP_AND:   r = a & b;
            OP_MVOP2: r = b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    exu_alu_req_arb #(
        .NREQ   (NREQ),
        .RR_ARB (RR_ARB),
        .IDX_W  (IDX_W)
    ) u_arb (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    // Accepts only from IDLE; never during reset.
    assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        sel_op  = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_op  = req_op[i*ALU_OP_W +: ALU_OP_W];
                sel_op1 = req_op1[i*XLEN +: XLEN];
                sel_op2 = req_op2[i*XLEN +: XLEN];
            end
        end
    end

    assign sel_amt   = sel_op2[SH_W-1:0];
    assign alu_res_d = alu_calc(sel_op, sel_op1, sel_op2);
    assign rr_ptr_d  = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    assign owner_oh  = NREQ'(1) << owner_q;

    // Final partial step covers counts that are not a multiple of SHIFT_STEP.
    assign step_amt = ({1'b0, cnt_q} >= STEP) ? STEP : {1'b0, cnt_q};
    assign cnt_d    = cnt_q - step_amt[SH_W-1:0];

    always_comb begin
        shreg_d = shreg_q;
        case (op_q)
            OP_SLL:  shreg_d = shreg_q << step_amt;
            OP_SRL:  shreg_d = shreg_q >> step_amt;
            default: shreg_d = $signed(shreg_q) >>> step_amt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q <= grant_idx;
                        op_q    <= sel_op;
                        if (RR_ARB != 0) rr_ptr_q <= rr_ptr_d;
                        if (is_shift_op(sel_op)) begin
                            shreg_q <= sel_op1;
                            cnt_q   <= sel_amt;
                            if (sel_amt == '0) begin
                                res_q       <= sel_op1;
                                rsp_valid_q <= grant;
                                state_q     <= ST_RESP;
                            end else begin
                                state_q <= ST_SHIFT;
                            end
                        end else begin
                            res_q       <= alu_res_d;
                            rsp_valid_q <= grant;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_d;
                    if (cnt_d == '0) begin
                        res_q       <= shreg_d;
                        rsp_valid_q <= owner_oh;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = res_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_exu_alu_shared_dpath.sv
// Bench for exu_alu_shared_dpath: instance 0 (SHIFT_STEP 1, round-robin) and
// instance 1 (SHIFT_STEP 8, fixed priority), checked against an arithmetic reference model.
module tb_exu_alu_shared_dpath;

    localparam int XLEN = 32;
    localparam int NREQ = 2;
    localparam int STEP_K [2] = '{1, 8};
    localparam int RR_K   [2] = '{1, 0};

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid [2];
    logic [NREQ-1:0]      req_ready [2];
    logic [NREQ*4-1:0]    req_op    [2];
    logic [NREQ*XLEN-1:0] req_op1   [2];
    logic [NREQ*XLEN-1:0] req_op2   [2];
    logic [NREQ-1:0]      rsp_valid [2];
    logic [NREQ-1:0]      rsp_ready [2];
    logic [XLEN-1:0]      rsp_res   [2];
    logic                 busy      [2];
    logic [1:0]           dbg_state [2];

    int n_total = 0;
    int n_bad   = 0;
    int ptr_m [2] = '{0, 0};

    exu_alu_shared_dpath #(.XLEN(XLEN), .NREQ(NREQ), .SHIFT_STEP(1), .RR_ARB(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_op1(req_op1[0]), .req_op2(req_op2[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_res(rsp_res[0]),
        .busy(busy[0]), .dbg_state(dbg_state[0])
    );

    exu_alu_shared_dpath #(.XLEN(XLEN), .NREQ(NREQ), .SHIFT_STEP(8), .RR_ARB(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_op1(req_op1[1]), .req_op2(req_op2[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_res(rsp_res[1]),
        .busy(busy[1]), .dbg_state(dbg_state[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        int n;
        sa = a;
        n  = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  return (a < b) ? 32'd1 : 32'd0;
            4'd4:  return a ^ b;
            4'd5:  return a | b;
            4'd6:  return a & b;
            4'd7:  return a << n;
            4'd8:  return a >> n;
            4'd9:  return sa >>> n;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [31:0] b, input int step);
        int n;
        n = int'(b[4:0]);
        if (op >= 4'd7 && op <= 4'd9) return 1 + (n + step - 1) / step;
        return 1;
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = '0;
            req_op[k]    = '0;
            req_op1[k]   = '0;
            req_op2[k]   = '0;
            rsp_ready[k] = 2'b11;
        end
    endtask

    // Issue one op on channel ch of instance k, check latency, result and return to idle.
    task automatic run_op(input int k, input int ch, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input string tag);
        int wait_c;
        int lat;
        logic [1:0] oh;
        oh = 2'b01 << ch;
        @(negedge clk);
        req_op[k][ch*4 +: 4]        = op;
        req_op1[k][ch*XLEN +: XLEN] = a;
        req_op2[k][ch*XLEN +: XLEN] = b;
        req_valid[k][ch]            = 1'b1;
        rsp_ready[k]                = 2'b11;
        #1;
        wait_c = 0;
        while (!req_ready[k][ch] && wait_c < 200) begin
            @(negedge clk); #1;
            wait_c++;
        end
        if (!req_ready[k][ch]) begin
            check_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
            req_valid[k][ch] = 1'b0;
            return;
        end
        if (RR_K[k] != 0) ptr_m[k] = (ch + 1) % NREQ;
        @(posedge clk); #1;
        req_valid[k][ch] = 1'b0;
        lat = 1;
        while (!rsp_valid[k][ch] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(model_lat(op, b, STEP_K[k])));
        check_eq({tag, "_res"}, 64'(rsp_res[k]), 64'(model_res(op, a, b)));
        check_eq({tag, "_vld"}, 64'(rsp_valid[k]), 64'(oh));
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, 64'(busy[k]), 64'd0);
    endtask

    // Both channels request continuously; grant order must follow the arbitration rule.
    task automatic arb_test(input int k, input string tag);
        int grants;
        int exp_ch;
        grants = 0;
        req_op[k]    = '0;
        req_op1[k]   = {32'd3, 32'd1};
        req_op2[k]   = {32'd4, 32'd2};
        rsp_ready[k] = 2'b11;
        req_valid[k] = 2'b11;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (req_ready[k] != 2'b00) begin
                exp_ch = (RR_K[k] != 0) ? ptr_m[k] : 0;
                check_eq(tag, 64'(req_ready[k]), 64'(2'b01 << exp_ch));
                if (RR_K[k] != 0) ptr_m[k] = (exp_ch + 1) % NREQ;
                grants++;
            end
        end
        req_valid[k] = 2'b00;
        check_eq({tag, "_count"}, 64'(grants), 64'd10);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic stall_test();
        @(negedge clk);
        req_op[0][3:0]      = 4'd0;
        req_op1[0][31:0]    = 32'd5;
        req_op2[0][31:0]    = 32'd6;
        req_valid[0]        = 2'b01;
        rsp_ready[0]        = 2'b10;
        #1;
        check_eq("stall_accept", 64'(req_ready[0]), 64'd1);
        ptr_m[0] = 1;
        @(posedge clk); #1;
        req_op[0][7:4]      = 4'd0;
        req_valid[0]        = 2'b10;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_vld", 64'(rsp_valid[0]), 64'd1);
            check_eq("stall_res", 64'(rsp_res[0]), 64'd11);
            check_eq("stall_busy", 64'(busy[0]), 64'd1);
            check_eq("stall_noacc", 64'(req_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        req_valid[0] = 2'b00;
        rsp_ready[0] = 2'b11;
        @(posedge clk); #1;
        check_eq("stall_release_busy", 64'(busy[0]), 64'd0);
        check_eq("stall_release_vld", 64'(rsp_valid[0]), 64'd0);
    endtask

    task automatic reset_test();
        int seen;
        @(negedge clk);
        req_op[0][3:0]   = 4'd7;
        req_op1[0][31:0] = 32'h0000_0001;
        req_op2[0][31:0] = 32'd20;
        req_valid[0]     = 2'b01;
        #1;
        check_eq("rst_sll_accept", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_mid_busy", 64'(busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_abort_busy", 64'(busy[0]), 64'd0);
        check_eq("rst_abort_vld", 64'(rsp_valid[0]), 64'd0);
        check_eq("rst_abort_state", 64'(dbg_state[0]), 64'd0);
        check_eq("rst_ready_masked", 64'(req_ready[0]), 64'd0);
        ptr_m[0] = 0;
        repeat (3) @(negedge clk);
        req_valid[0] = 2'b00;
        rst_n        = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid[0] != 2'b00) seen++;
        end
        check_eq("rst_no_response", 64'(seen), 64'd0);
        run_op(0, 0, 4'd0, 32'd100, 32'd23, "rst_after");
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          ch;
        idle_inputs();
        rst_n = 1'b0;
        req_valid[0] = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_vld", 64'(rsp_valid[0]), 64'd0);
        check_eq("reset_res", 64'(rsp_res[0]), 64'd0);
        check_eq("reset_busy", 64'(busy[0]), 64'd0);
        check_eq("reset_ready", 64'(req_ready[0]), 64'd0);
        check_eq("reset_state", 64'(dbg_state[0]), 64'd0);
        @(negedge clk);
        req_valid[0] = 2'b00;
        rst_n = 1'b1;

        run_op(0, 0, 4'd0,  32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
        run_op(0, 0, 4'd1,  32'h0000_0000, 32'h0000_0001, "sub_wrap");
        run_op(0, 1, 4'd2,  32'hFFFF_FFFF, 32'h0000_0001, "slt");
        run_op(0, 1, 4'd3,  32'hFFFF_FFFF, 32'h0000_0001, "sltu");
        run_op(0, 0, 4'd10, 32'hDEAD_BEEF, 32'h1234_5000, "mvop2");
        run_op(0, 1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reserved");
        run_op(0, 0, 4'd9,  32'h8000_0000, 32'd31, "sra31_s1");
        run_op(1, 0, 4'd9,  32'h8000_0000, 32'd31, "sra31_s8");
        run_op(0, 1, 4'd8,  32'hF0F0_0000, 32'd0,  "shift0_s1");
        run_op(1, 1, 4'd7,  32'h1234_5678, 32'd0,  "shift0_s8");
        run_op(1, 0, 4'd8,  32'h8000_0000, 32'd9,  "srl9_s8");

        arb_test(0, "arb_rr");
        arb_test(1, "arb_fixed");
        stall_test();
        reset_test();

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            ch = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000 | ($urandom & 32'hFF);
            run_op(i % 2, ch, op, a, b, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
